// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg
// Shared definitions for the multi-cycle shift sequencer: operation
// encodings, the controller state enum and the per-step shift limit.
// Optional feature macro: SHIFT_SEQ_ROR_EN (enables rotate-right for OP_ROR).
package shift_seq_pkg;

  // Operation encodings as presented on the op input
  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } op_e;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  // Largest shift the single-step shifter performs per cycle
  localparam int STEP_MAX = 3;

endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if
// Request/response bundle between the ALU issue logic (master) and the
// shift sequencer (slave).
//   start  - request strobe, sampled only while busy is low
//   op     - operation select (LSL, LSR, ASR, ROR)
//   din    - operand, sampled with start
//   shamt  - total shift amount, sampled with start
//   busy   - high while a request is in flight
//   done   - one-cycle pulse when dout becomes valid
//   dout   - result, held until the next accepted request
interface shift_sequencer_if #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
);
  logic               start;
  logic [1:0]         op;
  logic [WIDTH-1:0]   din;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   dout;

  modport master (output start, op, din, shamt, input busy, done, dout);
  modport slave  (input start, op, din, shamt, output busy, done, dout);
endinterface

// File: rtl/shift_step.sv
// shift_step
// Combinational single-step shifter moving the operand by 0..3 bits.
//   din  - value to shift
//   amt  - step amount (0..3)
//   op   - operation select
//   dout - shifted value
// Optional feature macro: SHIFT_SEQ_ROR_EN compiles in the rotate path;
// without it OP_ROR passes the operand through unchanged.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       amt,
  input  op_e              op,
  output logic [WIDTH-1:0] dout
);

  // ASR sign fill comes from the current working value, so iterating
  // this step reproduces a single-shot arithmetic shift.
  always_comb begin
    dout = din;
    case (op)
      OP_LSL: dout = din << amt;
      OP_LSR: dout = din >> amt;
      OP_ASR: dout = $unsigned($signed(din) >>> amt);
`ifdef SHIFT_SEQ_ROR_EN
      OP_ROR: begin
        case (amt)
          2'd1:    dout = {din[0],   din[WIDTH-1:1]};
          2'd2:    dout = {din[1:0], din[WIDTH-1:2]};
          2'd3:    dout = {din[2:0], din[WIDTH-1:3]};
          default: dout = din;
        endcase
      end
`endif
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-cycle shift controller: performs 0..(2^SHAMT_W-1) bit shifts on a
// WIDTH-bit operand by iterating a 0..3-bit step shifter.
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - shift_sequencer_if slave (start/op/din/shamt in,
//             busy/done/dout out)
// Optional feature macro: SHIFT_SEQ_ROR_EN enables rotate-right on OP_ROR.
// Without it OP_ROR completes in one edge and returns the operand unchanged.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input logic              clk,
  input logic              reset_n,
  shift_sequencer_if.slave bus
);

`ifdef SHIFT_SEQ_ROR_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  state_e             state;
  op_e                op_q;
  logic [SHAMT_W-1:0] rem;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   step_out;
  logic [1:0]         step;
  logic               busy_q;
  logic               done_q;
  logic               no_shift;

  // Step size is min(rem, STEP_MAX); rem fits in two bits when not clamped
  always_comb begin
    step = (rem > SHAMT_W'(STEP_MAX)) ? 2'(STEP_MAX) : rem[1:0];
  end

  // A request skips the SHIFT state entirely when there is nothing to do:
  // zero shift amount, or a rotate with rotation compiled out.
  always_comb begin
    no_shift = (bus.shamt == '0) || (!ROR_EN && (op_e'(bus.op) == OP_ROR));
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .din  (work),
    .amt  (step),
    .op   (op_q),
    .dout (step_out)
  );

  // Controller: latches the request in IDLE, consumes the shift amount in
  // steps in SHIFT, and pulses done for one cycle in DONE. busy and done
  // are registered alongside the state so they change with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= OP_LSL;
      rem    <= '0;
      work   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            work   <= bus.din;
            rem    <= bus.shamt;
            op_q   <= op_e'(bus.op);
            busy_q <= 1'b1;
            if (no_shift) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= step_out;
          rem  <= rem - SHAMT_W'(step);
          if (rem <= SHAMT_W'(STEP_MAX)) begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = work;

endmodule
